// File: rtl/pool_relu.sv
// 2x2 stride-2 signed max-pooling with optional ReLU over Q16.16 feature maps held in DRAM.
// Reads each window word by word, then writes one pooled word per window.
module pool_relu #(
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 18,
    parameter int FMAP_WIDTH  = 28,
    parameter int FMAP_HEIGHT = 28,
    parameter int NUM_CHNL    = 6,
    parameter logic [ADDR_WIDTH-1:0] IN_BASE  = 18'd0,
    parameter logic [ADDR_WIDTH-1:0] OUT_BASE = 18'd8192,
    parameter bit RELU_EN = 1'b1
) (
    input  logic                  clk,
    input  logic                  srstn,
    input  logic                  enable,
    input  logic                  dram_valid,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic [ADDR_WIDTH-1:0] addr_in,
    output logic [ADDR_WIDTH-1:0] addr_out,
    output logic                  dram_en_rd,
    output logic                  dram_en_wr,
    output logic                  done
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RD   = 2'd1;
    localparam logic [1:0] WR   = 2'd2;
    localparam logic [1:0] DONE = 2'd3;

    localparam logic [ADDR_WIDTH-1:0] ONE       = ADDR_WIDTH'(1);
    localparam logic [ADDR_WIDTH-1:0] MAP_W     = ADDR_WIDTH'(FMAP_WIDTH);
    localparam logic [ADDR_WIDTH-1:0] MAP_HW    = ADDR_WIDTH'(FMAP_HEIGHT * FMAP_WIDTH);
    localparam logic [ADDR_WIDTH-1:0] POOL_W    = ADDR_WIDTH'(FMAP_WIDTH / 2);
    localparam logic [ADDR_WIDTH-1:0] POOL_H    = ADDR_WIDTH'(FMAP_HEIGHT / 2);
    localparam logic [ADDR_WIDTH-1:0] POOL_HW   = ADDR_WIDTH'((FMAP_HEIGHT / 2) * (FMAP_WIDTH / 2));
    localparam logic [ADDR_WIDTH-1:0] LAST_CHNL = ADDR_WIDTH'(NUM_CHNL - 1);

    logic [1:0]                   state;
    logic [ADDR_WIDTH-1:0]        chnl;
    logic [ADDR_WIDTH-1:0]        prow;
    logic [ADDR_WIDTH-1:0]        pcol;
    logic [1:0]                   win_idx;
    logic signed [DATA_WIDTH-1:0] max_r;
    logic signed [DATA_WIDTH-1:0] max_next;
    logic [DATA_WIDTH-1:0]        pooled;
    logic [ADDR_WIDTH-1:0]        win_row;
    logic [ADDR_WIDTH-1:0]        win_col;
    logic [ADDR_WIDTH-1:0]        rd_addr;
    logic [ADDR_WIDTH-1:0]        wr_addr;
    logic                         last_pcol;
    logic                         last_prow;
    logic                         last_chnl;

    // win_idx bit 1 selects the bottom row, bit 0 the right column of the window
    always_comb begin
        win_row   = (prow << 1) + {{(ADDR_WIDTH-1){1'b0}}, win_idx[1]};
        win_col   = (pcol << 1) + {{(ADDR_WIDTH-1){1'b0}}, win_idx[0]};
        rd_addr   = IN_BASE + chnl * MAP_HW + win_row * MAP_W + win_col;
        wr_addr   = OUT_BASE + chnl * POOL_HW + prow * POOL_W + pcol;
        last_pcol = (pcol == POOL_W - ONE);
        last_prow = (prow == POOL_H - ONE);
        last_chnl = (chnl == LAST_CHNL);
    end

    always_comb begin
        max_next = max_r;
        if (win_idx == 2'd0 || $signed(data_in) > max_r) begin
            max_next = $signed(data_in);
        end
        pooled = (RELU_EN && max_next[DATA_WIDTH-1]) ? '0 : max_next;
    end

    assign dram_en_rd = (state == RD);
    assign dram_en_wr = (state == WR);
    assign done       = (state == DONE);
    assign addr_in    = (state == RD) ? rd_addr : '0;

    // The write word is captured as the last window read is accepted, so it is ready in WR.
    always_ff @(posedge clk or negedge srstn) begin
        if (!srstn) begin
            state    <= IDLE;
            chnl     <= '0;
            prow     <= '0;
            pcol     <= '0;
            win_idx  <= '0;
            max_r    <= '0;
            data_out <= '0;
            addr_out <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (enable) begin
                        state   <= RD;
                        chnl    <= '0;
                        prow    <= '0;
                        pcol    <= '0;
                        win_idx <= '0;
                    end
                end
                RD: begin
                    if (dram_valid) begin
                        max_r   <= max_next;
                        win_idx <= win_idx + 2'd1;
                        if (win_idx == 2'd3) begin
                            state    <= WR;
                            data_out <= pooled;
                            addr_out <= wr_addr;
                        end
                    end
                end
                WR: begin
                    state <= RD;
                    if (!last_pcol) begin
                        pcol <= pcol + ONE;
                    end else begin
                        pcol <= '0;
                        if (!last_prow) begin
                            prow <= prow + ONE;
                        end else begin
                            prow <= '0;
                            if (!last_chnl) begin
                                chnl <= chnl + ONE;
                            end else begin
                                chnl  <= '0;
                                state <= DONE;
                            end
                        end
                    end
                end
                DONE: begin
                    if (!enable) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
